// File: rtl/reg_read_arbiter.sv
// reg_read_arbiter: shares banked register-file read ports between the
// operand-collector read ports of a compute unit. Requests map to a bank by
// (reg_idx + wid) mod NumBanks. Each bank has its own round-robin arbiter and
// a BankLatency-deep pipeline that routes the bank response back to the
// requester that was granted.
// Optional feature: define REG_READ_ARB_STATS_EN to add per-bank grant and
// conflict counters (stat_grants_o, stat_conflicts_o).
module reg_read_arbiter #(
   parameter  int unsigned NumRequesters = 4,
   parameter  int unsigned NumBanks      = 2,
   parameter  int unsigned NumWarps      = 8,
   parameter  int unsigned RegIdxWidth   = 6,
   parameter  int unsigned RegWidth      = 32,
   parameter  int unsigned WarpWidth     = 32,
   parameter  int unsigned BankLatency   = 1,
   localparam int unsigned WidWidth      = (NumWarps > 1) ? $clog2(NumWarps) : 1,
   localparam int unsigned BankWidth     = (NumBanks > 1) ? $clog2(NumBanks) : 1,
   localparam int unsigned AddrWidth     = WidWidth + RegIdxWidth - $clog2(NumBanks),
   localparam int unsigned DataWidth     = RegWidth * WarpWidth
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic [NumRequesters-1:0]                    req_valid_i,
   input  logic [NumRequesters-1:0][WidWidth-1:0]      req_wid_i,
   input  logic [NumRequesters-1:0][RegIdxWidth-1:0]   req_reg_idx_i,
   output logic [NumRequesters-1:0]                    req_ready_o,
   output logic [NumRequesters-1:0]                    rsp_valid_o,
   output logic [NumRequesters-1:0][DataWidth-1:0]     rsp_data_o,
   output logic [NumBanks-1:0]                         bank_req_valid_o,
   output logic [NumBanks-1:0][AddrWidth-1:0]          bank_req_addr_o,
   input  logic [NumBanks-1:0]                         bank_rsp_valid_i,
   input  logic [NumBanks-1:0][DataWidth-1:0]          bank_rsp_data_i
`ifdef REG_READ_ARB_STATS_EN
   ,
   output logic [NumBanks-1:0][31:0]                   stat_grants_o,
   output logic [NumBanks-1:0][31:0]                   stat_conflicts_o
`endif
);

   localparam int unsigned BankShift = $clog2(NumBanks);
   localparam int unsigned ReqIdW    = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

   logic [NumRequesters-1:0][BankWidth-1:0]               req_bank;
   logic [NumRequesters-1:0][AddrWidth-1:0]               req_addr;
   logic [NumBanks-1:0]                                   grant_valid;
   logic [NumBanks-1:0][ReqIdW-1:0]                       grant_id;
   logic [NumBanks-1:0][ReqIdW-1:0]                       ptr_q, ptr_d;
   logic [NumBanks-1:0][BankLatency-1:0]                  pipe_vld_q, pipe_vld_d;
   logic [NumBanks-1:0][BankLatency-1:0][ReqIdW-1:0]      pipe_id_q, pipe_id_d;

   // Bank select and row address of every request; carry out of the bank sum is dropped.
   always_comb begin
      req_bank = '0;
      req_addr = '0;
      for (int unsigned r = 0; r < NumRequesters; r++) begin
         if (NumBanks > 1) begin
            req_bank[r] = BankWidth'(32'(req_reg_idx_i[r]) + 32'(req_wid_i[r]));
         end
         req_addr[r] = {req_wid_i[r], req_reg_idx_i[r][RegIdxWidth-1:BankShift]};
      end
   end

   // Per-bank round-robin search starting at the priority pointer; no grants in reset.
   always_comb begin
      logic [ReqIdW-1:0] cand;
      cand        = '0;
      grant_valid = '0;
      grant_id    = '0;
      for (int unsigned b = 0; b < NumBanks; b++) begin
         for (int unsigned i = 0; i < NumRequesters; i++) begin
            cand = ReqIdW'((32'(ptr_q[b]) + i) % NumRequesters);
            if (rst_ni && !grant_valid[b] && req_valid_i[cand] &&
                req_bank[cand] == BankWidth'(b)) begin
               grant_valid[b] = 1'b1;
               grant_id[b]    = cand;
            end
         end
      end
   end

   // Grant fans out to the requester's ready and the bank's read port in the same cycle.
   always_comb begin
      req_ready_o      = '0;
      bank_req_valid_o = grant_valid;
      bank_req_addr_o  = '0;
      for (int unsigned b = 0; b < NumBanks; b++) begin
         if (grant_valid[b]) begin
            req_ready_o[grant_id[b]] = 1'b1;
            bank_req_addr_o[b]       = req_addr[grant_id[b]];
         end
      end
   end

   // Next pointer and response-routing pipeline shift.
   always_comb begin
      ptr_d      = ptr_q;
      pipe_vld_d = '0;
      pipe_id_d  = '0;
      for (int unsigned b = 0; b < NumBanks; b++) begin
         if (grant_valid[b]) begin
            ptr_d[b] = ReqIdW'((32'(grant_id[b]) + 1) % NumRequesters);
         end
         pipe_vld_d[b][0] = grant_valid[b];
         pipe_id_d[b][0]  = grant_id[b];
         for (int unsigned s = 1; s < BankLatency; s++) begin
            pipe_vld_d[b][s] = pipe_vld_q[b][s-1];
            pipe_id_d[b][s]  = pipe_id_q[b][s-1];
         end
      end
   end

   // Pointer and pipeline state; reset drops everything in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q      <= '0;
         pipe_vld_q <= '0;
         pipe_id_q  <= '0;
      end else begin
         ptr_q      <= ptr_d;
         pipe_vld_q <= pipe_vld_d;
         pipe_id_q  <= pipe_id_d;
      end
   end

   // Steer each bank response to the requester recorded at the pipeline tail.
   always_comb begin
      rsp_valid_o = '0;
      rsp_data_o  = '0;
      for (int unsigned b = 0; b < NumBanks; b++) begin
         if (pipe_vld_q[b][BankLatency-1] && bank_rsp_valid_i[b]) begin
            rsp_valid_o[pipe_id_q[b][BankLatency-1]] = 1'b1;
            rsp_data_o[pipe_id_q[b][BankLatency-1]]  = bank_rsp_data_i[b];
         end
      end
   end

`ifdef REG_READ_ARB_STATS_EN
   logic [NumBanks-1:0][31:0] grants_q, grants_d;
   logic [NumBanks-1:0][31:0] conflicts_q, conflicts_d;

   // Saturating counters; a conflict is any cycle with two or more requesters on one bank.
   always_comb begin
      int unsigned cnt;
      cnt         = 0;
      grants_d    = grants_q;
      conflicts_d = conflicts_q;
      for (int unsigned b = 0; b < NumBanks; b++) begin
         cnt = 0;
         for (int unsigned r = 0; r < NumRequesters; r++) begin
            if (req_valid_i[r] && req_bank[r] == BankWidth'(b)) cnt++;
         end
         if (grant_valid[b] && grants_q[b] != '1) grants_d[b] = grants_q[b] + 32'd1;
         if (cnt > 1 && conflicts_q[b] != '1) conflicts_d[b] = conflicts_q[b] + 32'd1;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grants_q    <= '0;
         conflicts_q <= '0;
      end else begin
         grants_q    <= grants_d;
         conflicts_q <= conflicts_d;
      end
   end

   assign stat_grants_o    = grants_q;
   assign stat_conflicts_o = conflicts_q;
`endif

   // Simulation checks: banks answer exactly when a grant reaches the pipeline tail.
   always_ff @(posedge clk_i) begin
      assert ((NumBanks & (NumBanks - 1)) == 0) else $error("NumBanks must be a power of two");
      assert (BankLatency >= 1) else $error("BankLatency must be at least 1");
      if (rst_ni) begin
         for (int unsigned b = 0; b < NumBanks; b++) begin
            assert (bank_rsp_valid_i[b] == pipe_vld_q[b][BankLatency-1])
               else $error("bank %0d response valid does not match in-flight grant", b);
         end
      end
   end

endmodule
